// File: rtl/instr_encoder_loader.sv
// instr_encoder_loader: encodes symbolic RV32I instruction fields (LW, SW,
// ADD, SUB, AND, OR) into 32-bit words and writes them one after another
// into an instruction memory, acting as a program loader for benches and
// boot logic.
// Optional feature macro: ENC_NOP_PAD_EN. When defined, finishing a program
// fills the rest of instruction memory with NOPs (ADD x0,x0,x0).
module instr_encoder_loader #(
   parameter int DEPTH  = 64,
   parameter int ADDR_W = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [2:0]               op,
   input  logic [4:0]               rd,
   input  logic [4:0]               rs1,
   input  logic [4:0]               rs2,
   input  logic [11:0]              imm,
   input  logic                     clear,
   input  logic                     finish,
   output logic                     im_we,
   output logic [ADDR_W-1:0]        im_addr,
   output logic [31:0]              im_wdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     done,
   output logic                     err_illegal
);

   localparam int          CW       = $clog2(DEPTH) + 1;
   localparam logic [31:0] NOP_WORD = 32'h0000_0033;

`ifdef ENC_NOP_PAD_EN
   typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_PAD = 2'd1, ST_DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {ST_LOAD = 2'd0, ST_DONE = 2'd2} state_t;
`endif

   state_t              state;
   state_t              state_next;
   logic                accept;
   logic                legal;
   logic                wr_en;
   logic [31:0]         wr_data;
   logic [ADDR_W-1:0]   wr_addr;

   // Builds the RV32I word for one symbolic instruction; illegal ops give 0.
   function automatic logic [31:0] encode(input logic [2:0]  f_op,
                                          input logic [4:0]  f_rd,
                                          input logic [4:0]  f_rs1,
                                          input logic [4:0]  f_rs2,
                                          input logic [11:0] f_imm);
      logic [31:0] word;
      case (f_op)
         3'b000:  word = {f_imm, f_rs1, 3'b010, f_rd, 7'b0000011};
         3'b001:  word = {f_imm[11:5], f_rs2, f_rs1, 3'b010, f_imm[4:0], 7'b0100011};
         3'b010:  word = {7'b0000000, f_rs2, f_rs1, 3'b000, f_rd, 7'b0110011};
         3'b011:  word = {7'b0100000, f_rs2, f_rs1, 3'b000, f_rd, 7'b0110011};
         3'b100:  word = {7'b0000000, f_rs2, f_rs1, 3'b111, f_rd, 7'b0110011};
         3'b101:  word = {7'b0000000, f_rs2, f_rs1, 3'b110, f_rd, 7'b0110011};
         default: word = 32'h0000_0000;
      endcase
      return word;
   endfunction

   // The write pointer is the word count itself: both restart together and
   // advance together, and nothing wraps.
   assign full     = (count == CW'(DEPTH));
   assign done     = (state == ST_DONE);
   assign in_ready = (state == ST_LOAD) && !full && !clear;
   assign accept   = in_valid && in_ready;
   assign legal    = (op[2:1] != 2'b11);
   assign wr_addr  = ADDR_W'(count) << 2;

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: state is updated with non-blocking assignments so every flop
      // samples pre-edge values; blocking '=' here would create order-
      // dependent races between always_ff blocks.
      if (!rst_n) state <= ST_LOAD;
      else        state <= state_next;
   end

   // Next-state and write-request decode.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves a signal unassigned and no latch is inferred.
      state_next = state;
      wr_en      = 1'b0;
      wr_data    = encode(op, rd, rs1, rs2, imm);
      case (state)
         ST_LOAD: begin
            wr_en = accept && legal;
            if (finish) begin
`ifdef ENC_NOP_PAD_EN
               state_next = full ? ST_DONE : ST_PAD;
`else
               state_next = ST_DONE;
`endif
            end
         end
`ifdef ENC_NOP_PAD_EN
         ST_PAD: begin
            if (full) begin
               state_next = ST_DONE;
            end else begin
               wr_en   = 1'b1;
               wr_data = NOP_WORD;
               if (count == CW'(DEPTH - 1)) state_next = ST_DONE;
            end
         end
`endif
         ST_DONE: state_next = ST_DONE;
         default: state_next = ST_LOAD;
      endcase
      // clear overrides everything: pending fields and finish are dropped.
      if (clear) begin
         state_next = ST_LOAD;
         wr_en      = 1'b0;
      end
   end

   // Write port, word count and sticky illegal-op flag.
   always_ff @(posedge clk) begin
      if (!rst_n || clear) begin
         im_we       <= 1'b0;
         im_addr     <= '0;
         im_wdata    <= '0;
         count       <= '0;
         err_illegal <= 1'b0;
      end else begin
         im_we <= wr_en;
         if (wr_en) begin
            im_addr  <= wr_addr;
            im_wdata <= wr_data;
            count    <= count + CW'(1);
         end
         if (accept && !legal) err_illegal <= 1'b1;
      end
   end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench for instr_encoder_loader (DEPTH=8). Expected words
// come from a field-arithmetic encoder and a simple write-pointer model.
module tb_instr_encoder_loader;

   localparam int DEPTH  = 8;
   localparam int ADDR_W = 8;
`ifdef ENC_NOP_PAD_EN
   localparam int PAD = 1;
`else
   localparam int PAD = 0;
`endif

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        op;
   logic [4:0]        rd, rs1, rs2;
   logic [11:0]       imm;
   logic              clear, finish;
   logic              im_we;
   logic [ADDR_W-1:0] im_addr;
   logic [31:0]       im_wdata;
   logic [3:0]        count;
   logic              full, done, err_illegal;

   int total = 0;
   int bad   = 0;

   // model state for the randomized stream
   int          m_cnt;
   logic        m_err;
   logic [7:0]  m_addr;
   logic [31:0] m_data;

   logic [47:0] obs;
   assign obs = {im_we, im_addr, im_wdata, count, full, done, err_illegal};

   always #5 clk = ~clk;

   instr_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
      .clear(clear), .finish(finish), .im_we(im_we), .im_addr(im_addr),
      .im_wdata(im_wdata), .count(count), .full(full), .done(done),
      .err_illegal(err_illegal)
   );

   function automatic logic [47:0] exp_obs(input logic we, input int addr,
                                           input logic [31:0] data, input int cnt,
                                           input logic f, input logic d, input logic e);
      return {we, 8'(addr), data, 4'(cnt), f, d, e};
   endfunction

   // Reference encoder built from field values and shifts.
   function automatic logic [31:0] ref_encode(input int o, input int d, input int s1,
                                              input int s2, input int im);
      int f7, f3;
      case (o)
         0: return 32'((im << 20) + (s1 << 15) + (2 << 12) + (d << 7) + 3);
         1: return 32'((((im >> 5) & 127) << 25) + (s2 << 20) + (s1 << 15)
                       + (2 << 12) + ((im & 31) << 7) + 35);
         default: begin
            f7 = (o == 3) ? 32 : 0;
            f3 = (o == 4) ? 7 : (o == 5) ? 6 : 0;
            return 32'((f7 << 25) + (s2 << 20) + (s1 << 15) + (f3 << 12) + (d << 7) + 51);
         end
      endcase
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      in_valid = 0; clear = 0; finish = 0;
      op = 0; rd = 0; rs1 = 0; rs2 = 0; imm = 0;
   endtask

   task automatic set_instr(input logic [2:0] o, input logic [4:0] d, input logic [4:0] s1,
                            input logic [4:0] s2, input logic [11:0] im);
      in_valid = 1; op = o; rd = d; rs1 = s1; rs2 = s2; imm = im;
   endtask

   task automatic do_clear;
      idle(); clear = 1; tick(); idle();
   endtask

   // Follows the loader until done, checking every pad write, then checks
   // that the DONE state ignores new fields.
   task automatic wait_done(input int start_cnt, input int exp_pads, input string tag);
      int ptr = start_cnt;
      int n   = 0;
      for (int i = 0; i < 4 * DEPTH && !done; i++) begin
         tick();
         if (im_we) begin
            total++;
            if ({im_addr, im_wdata} !== {8'(ptr * 4), 32'h0000_0033}) begin
               bad++;
               $display("FAIL %s_pad_word got=%h exp=%h", tag, {im_addr, im_wdata},
                        {8'(ptr * 4), 32'h0000_0033});
            end
            ptr++; n++;
         end
      end
      total++;
      if ({done, 8'(n)} !== {1'b1, 8'(exp_pads)}) begin
         bad++;
         $display("FAIL %s_done_pads got done=%0b pads=%0d exp done=1 pads=%0d", tag, done, n, exp_pads);
      end
      set_instr(3'b010, 5'd1, 5'd1, 5'd1, 12'd0);
      #1;
      total++;
      if (in_ready !== 1'b0) begin
         bad++; $display("FAIL %s_done_ready got=%b exp=0", tag, in_ready);
      end
      tick(); tick(); idle();
      total++;
      if ({im_we, count, done} !== {1'b0, 4'(start_cnt + exp_pads), 1'b1}) begin
         bad++;
         $display("FAIL %s_done_hold got=%h exp=%h", tag, {im_we, count, done},
                  {1'b0, 4'(start_cnt + exp_pads), 1'b1});
      end
   endtask

   task automatic test_reset;
      logic [47:0] e;
      rst_n = 0;
      set_instr(3'($urandom_range(0, 7)), 5'($urandom), 5'($urandom), 5'($urandom), 12'($urandom));
      tick(); tick();
      e = exp_obs(0, 0, 0, 0, 0, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL reset_outputs got=%h exp=%h", obs, e); end
      idle(); #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
      rst_n = 1;
      tick();
   endtask

   task automatic test_add;
      logic [47:0] e;
      set_instr(3'b010, 5'd3, 5'd1, 5'd2, 12'd0);
      tick(); idle();
      e = exp_obs(1, 0, 32'h002081B3, 1, 0, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL add_write got=%h exp=%h", obs, e); end
   endtask

   task automatic test_back_to_back;
      logic [2:0]  t_op [5] = '{3'b011, 3'b000, 3'b001, 3'b100, 3'b101};
      logic [4:0]  t_rd [5] = '{5'd5, 5'd1, 5'd0, 5'd6, 5'd7};
      logic [4:0]  t_s1 [5] = '{5'd3, 5'd0, 5'd0, 5'd1, 5'd1};
      logic [4:0]  t_s2 [5] = '{5'd4, 5'd0, 5'd3, 5'd2, 5'd2};
      logic [11:0] t_im [5] = '{12'd0, 12'd8, 12'd12, 12'd0, 12'd0};
      logic [31:0] t_w  [5] = '{32'h404182B3, 32'h00802083, 32'h00302623,
                               32'h0020F333, 32'h0020E3B3};
      logic [47:0] e;
      for (int i = 0; i < 5; i++) begin
         set_instr(t_op[i], t_rd[i], t_s1[i], t_s2[i], t_im[i]);
         tick();
         e = exp_obs(1, 4 * (i + 1), t_w[i], i + 2, 0, 0, 0);
         total++;
         if (obs !== e) begin bad++; $display("FAIL b2b_word%0d got=%h exp=%h", i, obs, e); end
      end
      idle();
   endtask

   task automatic test_illegal;
      logic [47:0] e;
      set_instr(3'b110, 5'd9, 5'd9, 5'd9, 12'h7FF);
      tick(); idle();
      e = exp_obs(0, 8'h14, 32'h0020E3B3, 6, 0, 0, 1);
      total++;
      if (obs !== e) begin bad++; $display("FAIL illegal_op got=%h exp=%h", obs, e); end
      set_instr(3'b010, 5'd3, 5'd1, 5'd2, 12'd0);
      tick(); idle();
      e = exp_obs(1, 8'h18, 32'h002081B3, 7, 0, 0, 1);
      total++;
      if (obs !== e) begin bad++; $display("FAIL illegal_sticky got=%h exp=%h", obs, e); end
      clear = 1; set_instr(3'b010, 5'd3, 5'd1, 5'd2, 12'd0); #1;
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL clear_ready got=%b exp=0", in_ready); end
      tick(); idle();
      e = exp_obs(0, 0, 0, 0, 0, 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL clear_state got=%h exp=%h", obs, e); end
   endtask

   task automatic test_random_fill;
      logic [47:0] e;
      logic        we;
      int o, d, s1, s2, im;
      m_cnt = 0; m_err = 0; m_addr = 0; m_data = 0;
      for (int i = 0; i < 200 && m_cnt < DEPTH; i++) begin
         o = $urandom_range(0, 7); d = $urandom_range(0, 31);
         s1 = $urandom_range(0, 31); s2 = $urandom_range(0, 31); im = $urandom_range(0, 4095);
         idle();
         if ($urandom_range(0, 9) < 7) set_instr(3'(o), 5'(d), 5'(s1), 5'(s2), 12'(im));
         we = 0;
         if (in_valid) begin
            if (o >= 6) m_err = 1;
            else begin
               we = 1; m_addr = 8'(m_cnt * 4); m_data = ref_encode(o, d, s1, s2, im); m_cnt++;
            end
         end
         tick();
         e = exp_obs(we, m_addr, m_data, m_cnt, m_cnt == DEPTH, 0, m_err);
         total++;
         if (obs !== e) begin bad++; $display("FAIL random_cycle%0d got=%h exp=%h", i, obs, e); end
      end
      set_instr(3'b010, 5'd1, 5'd2, 5'd3, 12'd0);
      for (int i = 0; i < 3; i++) begin
         #1;
         total++;
         if (in_ready !== 1'b0) begin bad++; $display("FAIL full_ready%0d got=%b exp=0", i, in_ready); end
         tick();
         e = exp_obs(0, m_addr, m_data, DEPTH, 1, 0, m_err);
         total++;
         if (obs !== e) begin bad++; $display("FAIL full_hold%0d got=%h exp=%h", i, obs, e); end
      end
      idle();
   endtask

   task automatic test_finish_full;
      logic [47:0] e;
      finish = 1; tick(); idle();
      e = exp_obs(0, m_addr, m_data, DEPTH, 1, 1, m_err);
      total++;
      if (obs !== e) begin bad++; $display("FAIL finish_full got=%h exp=%h", obs, e); end
      wait_done(DEPTH, 0, "finish_full");
      do_clear();
   endtask

   task automatic test_finish_pad;
      for (int i = 0; i < 2; i++) begin
         set_instr(3'b100, 5'(i + 1), 5'd2, 5'd3, 12'd0); tick();
      end
      idle(); finish = 1; tick(); idle();
      total++;
      if ({im_we, count, done} !== {1'b0, 4'd2, PAD == 0}) begin
         bad++;
         $display("FAIL finish_pad_entry got=%h exp=%h", {im_we, count, done}, {1'b0, 4'd2, PAD == 0});
      end
      wait_done(2, PAD ? DEPTH - 2 : 0, "finish_pad");
      do_clear();
   endtask

   task automatic test_finish_accept;
      logic [47:0] e;
      set_instr(3'b011, 5'd5, 5'd3, 5'd4, 12'd0); finish = 1;
      tick(); idle();
      e = exp_obs(1, 0, 32'h404182B3, 1, 0, PAD == 0, 0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL finish_accept got=%h exp=%h", obs, e); end
      wait_done(1, PAD ? DEPTH - 1 : 0, "finish_accept");
      do_clear();
   endtask

   task automatic test_abort;
      logic [47:0] e;
      for (int k = 0; k < 2; k++) begin
         set_instr(3'b101, 5'd7, 5'd1, 5'd2, 12'd0); tick(); tick();
         if (k == 0) rst_n = 0; else clear = 1;
         set_instr(3'b000, 5'd1, 5'd0, 5'd0, 12'd8);
         tick(); idle(); rst_n = 1;
         e = exp_obs(0, 0, 0, 0, 0, 0, 0);
         total++;
         if (obs !== e) begin bad++; $display("FAIL abort%0d_state got=%h exp=%h", k, obs, e); end
         set_instr(3'b000, 5'd1, 5'd0, 5'd0, 12'd8); tick(); idle();
         e = exp_obs(1, 0, 32'h00802083, 1, 0, 0, 0);
         total++;
         if (obs !== e) begin bad++; $display("FAIL abort%0d_next got=%h exp=%h", k, obs, e); end
         do_clear();
      end
   endtask

   initial begin
      idle();
      rst_n = 0;
      #2;
      test_reset();
      test_add();
      test_back_to_back();
      test_illegal();
      test_random_fill();
      test_finish_full();
      test_finish_pad();
      test_finish_accept();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
